// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, memory-op codes, FSM state encodings,
// pipeline constants, the data-bus command payload and op-classification
// helpers used by the MEM pipeline stage.
package mem_access_pkg;

    localparam int unsigned REG_ADDR_W = 5;   // register address bus width
    localparam int unsigned REG_W      = 32;  // register / data bus width
    localparam int unsigned MEMOP_W    = 4;   // memory-op bus width
    localparam int unsigned STATE_W    = 2;   // FSM state width
    localparam int unsigned CNT_W      = 8;   // timeout counter width (TIMEOUT_CYCLES <= 255)
    localparam int unsigned SEL_W      = 4;   // byte-lane select width

    // Memory-op codes
    localparam logic [MEMOP_W-1:0] MEMOP_NOP = 4'd0;
    localparam logic [MEMOP_W-1:0] MEMOP_LB  = 4'd1;
    localparam logic [MEMOP_W-1:0] MEMOP_LBU = 4'd2;
    localparam logic [MEMOP_W-1:0] MEMOP_LH  = 4'd3;
    localparam logic [MEMOP_W-1:0] MEMOP_LHU = 4'd4;
    localparam logic [MEMOP_W-1:0] MEMOP_LW  = 4'd5;
    localparam logic [MEMOP_W-1:0] MEMOP_SB  = 4'd6;
    localparam logic [MEMOP_W-1:0] MEMOP_SH  = 4'd7;
    localparam logic [MEMOP_W-1:0] MEMOP_SW  = 4'd8;

    // FSM states
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACCESS = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE   = 2'd2;

    // Pipeline constants
    localparam logic [REG_W-1:0]      ZERO_WORD     = 32'h0000_0000;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'd0;

    // Data-bus command payload held for the duration of an access
    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] addr;
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] wdata;
    } bus_cmd_t;

    function automatic logic is_load(input logic [MEMOP_W-1:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
               (op == MEMOP_LHU) || (op == MEMOP_LW);
    endfunction

    function automatic logic is_store(input logic [MEMOP_W-1:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    function automatic logic is_mem(input logic [MEMOP_W-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0
    function automatic logic is_misaligned(input logic [MEMOP_W-1:0] op,
                                           input logic [1:0]         addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: mis = addr_lo[0];
            MEMOP_LW, MEMOP_SW:            mis = |addr_lo;
            default:                       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational big-endian byte-lane steering.
// Ports:
//   memop      - memory op code
//   addr_lo    - effective address bits [1:0]
//   store_data - store operand (rt)
//   rdata      - latched bus read data
//   sel        - byte-lane select, bit 3 = bits 31:24
//   wdata      - lane-replicated store data
//   load_data  - extracted and sign/zero-extended load result
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [MEMOP_W-1:0] memop,
    input  logic [1:0]         addr_lo,
    input  logic [REG_W-1:0]   store_data,
    input  logic [REG_W-1:0]   rdata,
    output logic [SEL_W-1:0]   sel,
    output logic [REG_W-1:0]   wdata,
    output logic [REG_W-1:0]   load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Address 0 is the most significant byte (big-endian)
    always_comb begin
        byte_lane = rdata[31:24];
        case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            2'd3:    byte_lane = rdata[7:0];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Lane select and store replication
    always_comb begin
        sel   = '0;
        wdata = store_data;
        case (memop)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: sel = SEL_W'(4'b1000 >> addr_lo);
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: sel = addr_lo[1] ? 4'b0011 : 4'b1100;
            MEMOP_LW, MEMOP_SW:            sel = 4'b1111;
            default:                       sel = '0;
        endcase
        case (memop)
            MEMOP_SB: wdata = {4{store_data[7:0]}};
            MEMOP_SH: wdata = {2{store_data[15:0]}};
            default:  wdata = store_data;
        endcase
    end

    // Load extraction with sign/zero extension
    always_comb begin
        load_data = ZERO_WORD;
        case (memop)
            MEMOP_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            MEMOP_LBU: load_data = {24'h00_0000, byte_lane};
            MEMOP_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            MEMOP_LHU: load_data = {16'h0000, half_lane};
            MEMOP_LW:  load_data = rdata;
            default:   load_data = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. ALU results pass straight through; loads
// and stores run a multi-cycle data-bus transaction (IDLE -> ACCESS -> DONE)
// with stall_req held until completion or timeout abort.
// Ports:
//   clock, reset                     - clock, async active-high reset
//   ex_wd/ex_wreg/ex_wdata           - writeback info from ex_mem
//   ex_memop/ex_mem_addr/ex_store_data - memory op, address, store operand
//   mem_wd/mem_wreg/mem_wdata        - writeback info to mem_wb
//   stall_req                        - hold upstream; mem_wb must not capture
//   bus_req/bus_we/bus_addr/bus_sel/bus_wdata - registered data-bus command
//   bus_ack/bus_rdata                - completion strobe and read data
//   misalign                         - misaligned op presented in IDLE
//   bus_timeout                      - one-cycle pulse on timeout abort
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [REG_W-1:0]      ex_wdata,
    input  logic [MEMOP_W-1:0]    ex_memop,
    input  logic [REG_W-1:0]      ex_mem_addr,
    input  logic [REG_W-1:0]      ex_store_data,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [REG_W-1:0]      mem_wdata,
    output logic                  stall_req,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [REG_W-1:0]      bus_addr,
    output logic [SEL_W-1:0]      bus_sel,
    output logic [REG_W-1:0]      bus_wdata,
    input  logic                  bus_ack,
    input  logic [REG_W-1:0]      bus_rdata,
    output logic                  misalign,
    output logic                  bus_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0] state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    bus_cmd_t           bus_q, bus_d;
    logic               bus_req_d;
    logic               bus_timeout_d;
    logic [REG_W-1:0]   rdata_q, rdata_d;
    logic               aborted, aborted_d;

    logic [SEL_W-1:0]   lane_sel;
    logic [REG_W-1:0]   lane_wdata;
    logic [REG_W-1:0]   load_data;

    logic               op_is_mem;
    logic               op_is_load;
    logic               op_misaligned;

    assign op_is_mem     = is_mem(ex_memop);
    assign op_is_load    = is_load(ex_memop);
    assign op_misaligned = is_misaligned(ex_memop, ex_mem_addr[1:0]);

    // Upstream is stalled during the access, so ex_* still describe this op in DONE
    mem_lane_align u_lane_align (
        .memop      (ex_memop),
        .addr_lo    (ex_mem_addr[1:0]),
        .store_data (ex_store_data),
        .rdata      (rdata_q),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    // State and bus-command registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bus_q       <= '0;
            bus_req     <= 1'b0;
            bus_timeout <= 1'b0;
            rdata_q     <= ZERO_WORD;
            aborted     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            bus_q       <= bus_d;
            bus_req     <= bus_req_d;
            bus_timeout <= bus_timeout_d;
            rdata_q     <= rdata_d;
            aborted     <= aborted_d;
        end
    end

    // Next-state and next bus command
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        bus_d         = bus_q;
        bus_req_d     = bus_req;
        bus_timeout_d = 1'b0;
        rdata_d       = rdata_q;
        aborted_d     = aborted;
        case (state)
            ST_IDLE: begin
                if (op_is_mem && !op_misaligned) begin
                    bus_d.we    = is_store(ex_memop);
                    bus_d.addr  = {ex_mem_addr[REG_W-1:2], 2'b00};
                    bus_d.sel   = lane_sel;
                    bus_d.wdata = lane_wdata;
                    bus_req_d   = 1'b1;
                    cnt_d       = '0;
                    aborted_d   = 1'b0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ack takes priority over an expiry in the same cycle
                if (bus_ack) begin
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    bus_req_d     = 1'b0;
                    bus_timeout_d = 1'b1;
                    aborted_d     = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Writeback/stall outputs, combinational so ALU results see no added latency
    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = WRITE_DISABLE;
        mem_wdata = ex_wdata;
        stall_req = 1'b0;
        misalign  = 1'b0;
        if (reset) begin
            mem_wd    = NOP_REG_ADDR;
            mem_wdata = ZERO_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!op_is_mem) begin
                        mem_wreg = ex_wreg;
                    end else if (op_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
                ST_ACCESS: begin
                    stall_req = 1'b1;
                end
                ST_DONE: begin
                    if (op_is_load && !aborted) begin
                        mem_wreg  = WRITE_ENABLE;
                        mem_wdata = load_data;
                    end
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

    assign bus_we    = bus_q.we;
    assign bus_addr  = bus_q.addr;
    assign bus_sel   = bus_q.sel;
    assign bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a
// behavioural model of lane steering, extension and transaction timing.
module tb_mem_access;

    localparam int TO = 4;

    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] LB  = 4'd1;
    localparam logic [3:0] LBU = 4'd2;
    localparam logic [3:0] LH  = 4'd3;
    localparam logic [3:0] LHU = 4'd4;
    localparam logic [3:0] LW  = 4'd5;
    localparam logic [3:0] SB  = 4'd6;
    localparam logic [3:0] SH  = 4'd7;
    localparam logic [3:0] SW  = 4'd8;

    logic        clock;
    logic        reset;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stall_req;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        misalign;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_wd         (ex_wd),
        .ex_wreg       (ex_wreg),
        .ex_wdata      (ex_wdata),
        .ex_memop      (ex_memop),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mem_wd        (mem_wd),
        .mem_wreg      (mem_wreg),
        .mem_wdata     (mem_wdata),
        .stall_req     (stall_req),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_sel       (bus_sel),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .misalign      (misalign),
        .bus_timeout   (bus_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: access size in bytes
    function automatic int op_size(input logic [3:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit op_load(input logic [3:0] op);
        return op >= LB && op <= LW;
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return op >= SB && op <= SW;
    endfunction

    // Model: lanes covered by the access, MSB lane = lowest byte address
    function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] a);
        int lo;
        int sz;
        int s;
        lo = int'(a[1:0]);
        sz = op_size(op);
        s = 0;
        for (int b = 0; b < sz; b++) s = s | (1 << (3 - (lo - (lo % sz)) - b));
        return 4'(s);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
        if (op == SB) return 32'(sd[7:0]) * 32'h0101_0101;
        if (op == SH) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        int lo;
        logic [31:0] v;
        lo = int'(a[1:0]);
        case (op)
            LB, LBU: begin
                v = (rd >> (8 * (3 - lo))) & 32'hFF;
                if (op == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            LH, LHU: begin
                v = (rd >> (16 * (1 - lo / 2))) & 32'hFFFF;
                if (op == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Present one op and follow it to completion; ack_delay > TO means no ack
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int ack_delay, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdat);
        bit mis;
        bit to;
        @(posedge clock); #1;
        ex_memop      = op;
        ex_mem_addr   = addr;
        ex_store_data = sd;
        ex_wd         = wd;
        ex_wreg       = wreg;
        ex_wdata      = wdat;
        bus_ack       = (op == NOP) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata     = $urandom;
        @(negedge clock);
        if (op == NOP) begin
            chk("nop_wd", 32'(mem_wd), 32'(wd));
            chk("nop_wreg", 32'(mem_wreg), 32'(wreg));
            chk("nop_wdata", mem_wdata, wdat);
            chk("nop_stall", 32'(stall_req), 32'd0);
            chk("nop_bus_req", 32'(bus_req), 32'd0);
            chk("nop_timeout", 32'(bus_timeout), 32'd0);
            return;
        end
        mis = (int'(addr[1:0]) % op_size(op)) != 0;
        if (mis) begin
            chk("mis_flag", 32'(misalign), 32'd1);
            chk("mis_wreg", 32'(mem_wreg), 32'd0);
            chk("mis_stall", 32'(stall_req), 32'd0);
            @(posedge clock); #1;
            chk("mis_bus_req", 32'(bus_req), 32'd0);
            return;
        end
        chk("idle_stall", 32'(stall_req), 32'd1);
        chk("idle_misalign", 32'(misalign), 32'd0);
        chk("idle_wreg", 32'(mem_wreg), 32'd0);
        to = ack_delay > TO;
        for (int k = 1; k <= TO; k++) begin
            @(posedge clock); #1;
            bus_ack   = (k == ack_delay);
            bus_rdata = (k == ack_delay) ? rd : $urandom;
            @(negedge clock);
            chk("acc_bus_req", 32'(bus_req), 32'd1);
            chk("acc_stall", 32'(stall_req), 32'd1);
            chk("acc_timeout", 32'(bus_timeout), 32'd0);
            if (k == 1) begin
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_sel", 32'(bus_sel), 32'(exp_sel(op, addr)));
                chk("bus_we", 32'(bus_we), 32'(op_store(op)));
                if (op_store(op)) chk("bus_wdata", bus_wdata, exp_wdata(op, sd));
            end
            if (k == ack_delay) break;
        end
        @(posedge clock); #1;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        @(negedge clock);
        chk("done_stall", 32'(stall_req), 32'd0);
        chk("done_bus_req", 32'(bus_req), 32'd0);
        chk("done_timeout", 32'(bus_timeout), 32'(to));
        chk("done_wd", 32'(mem_wd), 32'(wd));
        chk("done_wreg", 32'(mem_wreg), 32'(op_load(op) && !to));
        if (op_load(op) && !to) chk("done_wdata", mem_wdata, exp_load(op, addr, rd));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        int          sz;

        reset         = 1'b1;
        ex_wd         = 5'd7;
        ex_wreg       = 1'b1;
        ex_wdata      = 32'hDEAD_BEEF;
        ex_memop      = NOP;
        ex_mem_addr   = '0;
        ex_store_data = '0;
        bus_ack       = 1'b0;
        bus_rdata     = '0;
        repeat (2) @(negedge clock);
        chk("rst_wd", 32'(mem_wd), 32'd0);
        chk("rst_wreg", 32'(mem_wreg), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_timeout", 32'(bus_timeout), 32'd0);
        reset = 1'b0;

        // Directed cases
        run_op(NOP, 32'h0, 32'h0, 32'h0, 0, 5'd5, 1'b1, 32'h1234_5678);
        run_op(LB,  32'h100, 32'h0, 32'h80FF_0000, 3, 5'd3, 1'b1, 32'h0);
        run_op(LHU, 32'h202, 32'h0, 32'h0000_8001, 2, 5'd4, 1'b1, 32'h0);
        run_op(LH,  32'h202, 32'h0, 32'h0000_8001, 1, 5'd6, 1'b1, 32'h0);
        run_op(SB,  32'h303, 32'h0000_00AB, 32'h0, 2, 5'd8, 1'b1, 32'h0);
        run_op(LW,  32'h400, 32'h0, 32'h0, TO + 1, 5'd9, 1'b1, 32'h0);
        run_op(NOP, 32'h0, 32'h0, 32'h0, 0, 5'd10, 1'b1, 32'hCAFE_0001);
        run_op(LW,  32'h101, 32'h0, 32'h0, 1, 5'd11, 1'b1, 32'h0);
        run_op(LW,  32'h500, 32'h0, 32'h1357_9BDF, TO, 5'd12, 1'b1, 32'h0);
        run_op(SH,  32'h602, 32'h0000_BEEF, 32'h0, 1, 5'd13, 1'b1, 32'h0);

        // Reset asserted in the middle of an access
        @(posedge clock); #1;
        ex_memop    = LW;
        ex_mem_addr = 32'h700;
        @(posedge clock); #1;
        chk("mid_bus_req", 32'(bus_req), 32'd1);
        @(negedge clock); #1;
        reset    = 1'b1;
        ex_memop = NOP;
        #1;
        chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        chk("mid_rst_wreg", 32'(mem_wreg), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(NOP, 32'h0, 32'h0, 32'h0, 0, 5'd14, 1'b1, 32'h0BAD_F00D);

        // Randomized ops
        for (int i = 0; i < 300; i++) begin
            op   = 4'($urandom_range(0, 8));
            addr = $urandom;
            sz   = op_size(op);
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
            run_op(op, addr, $urandom, $urandom, int'($urandom_range(1, TO + 2)),
                   5'($urandom), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
MEM pipeline stage between ex_mem and mem_wb. It passes ALU results straight through. For load/store ops it runs a multi-cycle data-bus transaction, raising stall_req until the access completes. It performs big-endian byte-lane steering and sign/zero extension, and drives mem_wd/mem_wreg/mem_wdata into mem_wb.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for bus_ack before abort; legal range 1..255

Ports:
clock  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
ex_wd  input  5 (`RegisterAddressBus)  destination register from ex_mem
ex_wreg  input  1  write-enable from ex_mem
ex_wdata  input  32 (`RegisterBus)  ALU result from ex_mem
ex_memop  input  4 (`MemOpBus)  memory op: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW
ex_mem_addr  input  32  effective address
ex_store_data  input  32  store data (rt)
mem_wd  output  5  to mem_wb
mem_wreg  output  1  to mem_wb
mem_wdata  output  32  to mem_wb
stall_req  output  1  hold ex_mem/earlier stages; mem_wb must not capture while high
bus_req  output  1  registered; data-bus request
bus_we  output  1  registered; 1 = store
bus_addr  output  32  registered; word address {addr[31:2],2'b00}
bus_sel  output  4  registered; byte lanes, bit 3 = bits 31:24
bus_wdata  output  32  registered; lane-replicated store data
bus_ack  input  1  single-cycle completion strobe
bus_rdata  input  32  read data, valid with bus_ack
misalign  output  1  combinational; high while a misaligned op is presented in IDLE
bus_timeout  output  1  registered one-cycle pulse on timeout abort

Behaviour:
- Reset (async, active-high): state IDLE, timeout counter 0, bus_req/bus_we/bus_timeout 0, bus_addr/bus_sel/bus_wdata 0, latched read data 0. While reset is high, mem_wd=`NOPRegisterAddress, mem_wreg=`WriteDisable, mem_wdata=`ZeroWord, stall_req=0.
- States: IDLE, ACCESS, DONE.
- IDLE, ex_memop=NOP: outputs pass through combinationally (mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=ex_wdata), stall_req=0. Zero added latency.
- IDLE, misaligned op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus access, misalign=1, mem_wreg=0, stall_req=0. The op retires as a bubble.
- IDLE, aligned mem op: stall_req=1. Next edge: bus_req=1, bus_we/addr/sel/wdata loaded, counter cleared, go to ACCESS.
- Lane map (big-endian):
  - Byte ops: addr[1:0]=0..3 -> sel 1000/0100/0010/0001.
  - Half ops: addr[1]=0 -> 1100, addr[1]=1 -> 0011.
  - Word ops: sel 1111.
- Store data: SB replicates byte x4; SH replicates half x2; SW uses the word unchanged.
- ACCESS: stall_req=1, bus_req held, counter increments each cycle.
  - bus_ack: latch bus_rdata, drop bus_req, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: drop bus_req, pulse bus_timeout, mark the op aborted, go to DONE.
  - ack and expiry in the same cycle: ack wins.
- DONE (exactly one cycle): stall_req=0, mem_wd=ex_wd.
  - Load, not aborted: mem_wreg=1, mem_wdata=extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Store or aborted op: mem_wreg=0.
  - Next edge returns to IDLE. A new op then seen in IDLE is the next instruction, because the upstream advanced on this edge.
- bus_ack while IDLE or DONE is ignored.
- Reset asserted mid-ACCESS: bus_req drops immediately (async); no completion is reported.

Decomposition:
- Shared defines file: `MemOpBus width plus op codes `MEMOP_NOP/LB/LBU/LH/LHU/LW/SB/SH/SW, state encodings, and the existing `RegisterAddressBus/`RegisterBus/`ZeroWord/`WriteDisable/`NOPRegisterAddress.
- One combinational sub-module, mem_lane_align: computes sel, replicated store data, and load extraction/extension from memop, addr[1:0] and rdata.

Test Plan:
- ALU pass-through: memop=NOP, ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678 -> same values on mem_* in the same cycle; stall_req=0; bus_req never rises.
- LB: addr=0x100, memop=LB, bus_ack 3 cycles after bus_req, rdata=0x80FF_0000 -> bus_sel=1000, bus_addr=0x100; stall_req high 4 cycles; DONE gives mem_wreg=1, mem_wdata=0xFFFF_FF80.
- LHU vs LH: addr=0x202, rdata=0x0000_8001 -> sel=0011; LHU yields 0x0000_8001, LH yields 0xFFFF_8001.
- SB: addr=0x303, store_data=0x0000_00AB -> bus_we=1, sel=0001, bus_wdata=0xABAB_ABAB; DONE gives mem_wreg=0.
- Timeout: TIMEOUT_CYCLES=4, LW with no ack -> bus_req high exactly 4 cycles; bus_timeout pulses once; DONE gives mem_wreg=0; next NOP passes through.
- Misaligned + reset: LW addr=0x101 -> misalign=1, no bus_req, mem_wreg=0. Separately, assert reset in ACCESS -> bus_req=0 the same cycle, state IDLE.
